// File: rtl/keypad_if.sv
// Keypad scanner pin and key-output bundle.
// The master side is the scanner itself; the slave side is the pins plus the display/shift consumer.
interface keypad_if;
  logic [3:0] inputrows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  inputrows,
    output cols,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output inputrows,
    input  cols,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobing, row synchronizer/debounce,
// and one key_valid pulse per accepted press (first key wins, no rollover).
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic     clk,
  input  logic     reset,
  keypad_if.master kp
);

  localparam int unsigned DW = $clog2(SCAN_DIV) + 1;
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    rows_m_q, rows_s_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cols_q, cols_d;
  logic [1:0]    cap_row_q, cap_row_d;
  logic [1:0]    cap_col_q, cap_col_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;

  logic          row_hit;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    cols_next;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // Lowest set row wins when several rows are active together.
  function automatic logic [1:0] lowest_row(input logic [3:0] rows);
    logic [1:0] idx;
    if (rows[0])      idx = 2'd0;
    else if (rows[1]) idx = 2'd1;
    else if (rows[2]) idx = 2'd2;
    else              idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] cols);
    logic [1:0] idx;
    if (cols[0])      idx = 2'd0;
    else if (cols[1]) idx = 2'd1;
    else if (cols[2]) idx = 2'd2;
    else              idx = 2'd3;
    return idx;
  endfunction

  assign row_hit   = rows_s_q[cap_row_q];
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  assign cols_next = {cols_q[2:0], cols_q[3]};

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    cnt_d       = cnt_q;
    cols_d      = cols_q;
    cap_row_d   = cap_row_q;
    cap_col_d   = cap_col_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    case (state_q)
      ST_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (rows_s_q != 4'b0000) begin
            state_d   = ST_DEBOUNCE;
            cnt_d     = '0;
            cap_row_d = lowest_row(rows_s_q);
            cap_col_d = col_index(cols_q);
          end else begin
            cols_d = cols_next;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (!row_hit) begin
          state_d = ST_SCAN;
          cols_d  = cols_next;
          dwell_d = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_HELD;
          key_code_d  = key_map(cap_row_q, cap_col_q);
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_HELD: begin
        if (!row_hit) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end
      end

      ST_RELEASE: begin
        if (row_hit) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_SCAN;
          key_held_d = 1'b0;
          cols_d     = cols_next;
          dwell_d    = '0;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_SCAN;
      rows_m_q    <= '0;
      rows_s_q    <= '0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      cols_q      <= 4'b0001;
      cap_row_q   <= '0;
      cap_col_q   <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_m_q    <= kp.inputrows;
      rows_s_q    <= rows_m_q;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      cols_q      <= cols_d;
      cap_row_q   <= cap_row_d;
      cap_col_q   <= cap_col_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign kp.cols      = cols_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: reset, column rotation, clean and bouncy
// press/release, multi-key priority and reset while a key is held.
module tb_keypad_scanner;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int checks      = 0;
  int errors      = 0;
  int pulses      = 0;
  int double_vld  = 0;
  int held_low    = 0;
  int cols_off    = 0;
  logic prev_vld  = 1'b0;
  logic [3:0] watch_cols = 4'b0001;

  keypad_if kp ();

  keypad_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and track pulses, held and column activity.
  task automatic tick();
    @(negedge clk);
    if (kp.key_valid === 1'b1) begin
      pulses++;
      if (prev_vld) double_vld++;
    end
    prev_vld = (kp.key_valid === 1'b1);
    if (kp.key_held !== 1'b1) held_low++;
    if (kp.cols !== watch_cols) cols_off++;
  endtask

  task automatic wait_cols(input string tag, input logic [3:0] target, input int budget);
    int n = 0;
    while (kp.cols !== target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(kp.cols), 32'(target));
  endtask

  task automatic wait_release(input string tag, input int budget);
    int n = 0;
    while (kp.key_held !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(kp.key_held), 32'd0);
  endtask

  initial begin
    kp.inputrows = 4'b0000;

    // 1. reset values and column rotation
    for (int i = 0; i < 5; i++) tick();
    check("rst_cols",  32'(kp.cols),      32'h1);
    check("rst_code",  32'(kp.key_code),  32'h0);
    check("rst_valid", 32'(kp.key_valid), 32'h0);
    check("rst_held",  32'(kp.key_held),  32'h0);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] exp_cols;
      tick();
      exp_cols = 4'b0001 << (((i + 1) / 4) % 4);
      check("rotate_cols", 32'(kp.cols), 32'(exp_cols));
    end

    // 2. clean press of row2 on column0 -> key 7
    wait_cols("t2_start_cols", 4'b0001, 8);
    kp.inputrows = 4'b0100;
    pulses = 0; cols_off = 0; watch_cols = 4'b0001;
    for (int i = 0; i < 100; i++) tick();
    check("t2_pulses",   32'(pulses),      32'd1);
    check("t2_code",     32'(kp.key_code), 32'h7);
    check("t2_held",     32'(kp.key_held), 32'd1);
    check("t2_cols_frz", 32'(cols_off),    32'd0);
    kp.inputrows = 4'b0000;
    wait_release("t2_release", 12);
    check("t2_resume_cols", 32'(kp.cols), 32'h2);

    // 3. press bounce on column1: abandoned, no pulse
    kp.inputrows = 4'b1000;
    pulses = 0;
    for (int i = 0; i < 3; i++) tick();
    kp.inputrows = 4'b0000;
    wait_cols("t3_resume_cols", 4'b0100, 20);
    check("t3_pulses", 32'(pulses),      32'd0);
    check("t3_code",   32'(kp.key_code), 32'h7);
    check("t3_held",   32'(kp.key_held), 32'd0);

    // 4. release bounce on column2 row1 -> key 6, single pulse
    kp.inputrows = 4'b0010;
    pulses = 0;
    for (int i = 0; i < 20; i++) tick();
    check("t4_code",   32'(kp.key_code), 32'h6);
    check("t4_pulses", 32'(pulses),      32'd1);
    held_low = 0;
    kp.inputrows = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
    kp.inputrows = 4'b0010;
    for (int i = 0; i < 20; i++) tick();
    check("t4_held_kept", 32'(held_low), 32'd0);
    kp.inputrows = 4'b0000;
    wait_release("t4_release", 12);
    check("t4_pulses_end", 32'(pulses),  32'd1);
    check("t4_resume_cols", 32'(kp.cols), 32'h8);

    // 5. multi-key: lowest row wins, extra rows ignored while held
    wait_cols("t5_start_cols", 4'b0001, 40);
    kp.inputrows = 4'b1001;
    pulses = 0;
    for (int i = 0; i < 20; i++) tick();
    check("t5_code",   32'(kp.key_code), 32'h1);
    check("t5_pulses", 32'(pulses),      32'd1);
    kp.inputrows = 4'b1101;
    for (int i = 0; i < 20; i++) tick();
    check("t5_code_kept", 32'(kp.key_code), 32'h1);
    check("t5_no_extra",  32'(pulses),      32'd1);
    check("t5_held",      32'(kp.key_held), 32'd1);

    // 6. reset while held, key re-accepted as a fresh press
    reset = 1'b0;
    tick();
    check("t6_cols",  32'(kp.cols),      32'h1);
    check("t6_held",  32'(kp.key_held),  32'h0);
    check("t6_code",  32'(kp.key_code),  32'h0);
    check("t6_valid", 32'(kp.key_valid), 32'h0);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) tick();
    check("t6_pulses", 32'(pulses),      32'd1);
    check("t6_code2",  32'(kp.key_code), 32'h1);
    check("t6_held2",  32'(kp.key_held), 32'd1);
    kp.inputrows = 4'b0000;
    wait_release("t6_release", 12);

    check("no_double_valid", 32'(double_vld), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
